// File: rtl/pingpong_bank_ctrl.sv
// N-way ping-pong FIFO bank controller: fills banks round-robin, drains full banks to the consumer.
// Optional macro PPB_AUTO_RECOVER_EN: ERROR holds bank resets for 4 cycles, then restarts from INIT.
module pingpong_bank_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int IDX_W     = $clog2(NUM_BANKS),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_BANKS-1:0] full,
    input  logic [NUM_BANKS-1:0] empty,
    input  logic                 src_valid,
    input  logic                 dst_ready,
    output logic [NUM_BANKS-1:0] bank_rst,
    output logic [NUM_BANKS-1:0] wr_en,
    output logic [NUM_BANKS-1:0] rd_en,
    output logic [IDX_W-1:0]     wr_bank,
    output logic [IDX_W-1:0]     rd_bank,
    output logic [IDX_W:0]       occ,
    output logic                 src_stall,
    output logic                 err,
    output logic [CNT_W-1:0]     xfer_cnt
);

    typedef enum logic [1:0] {
        INIT       = 2'b00,
        WAIT_EMPTY = 2'b01,
        STREAM     = 2'b10,
        ERROR      = 2'b11
    } state_t;

    localparam logic [IDX_W:0]   NB       = (IDX_W+1)'(NUM_BANKS);
    localparam logic [IDX_W:0]   OCC_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  wr_bank_r, rd_bank_r;
    logic [IDX_W:0]    occ_r;
    logic              draining_r;
    logic              err_r;
    logic [CNT_W-1:0]  xfer_cnt_r;
    logic              commit_s, drain_done_s, fault_s, has_room_s, has_data_s;
`ifdef PPB_AUTO_RECOVER_EN
    logic [1:0]        recover_cnt_r;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_ONE;
    endfunction

    assign has_room_s   = (occ_r < NB);
    assign has_data_s   = (occ_r != {(IDX_W+1){1'b0}});
    assign commit_s     = (state_r == STREAM) && has_room_s && full[wr_bank_r];
    assign drain_done_s = (state_r == STREAM) && has_data_s && draining_r && empty[rd_bank_r];
    // A committed bank that is neither full nor being drained has lost its data.
    assign fault_s      = (|(full & empty)) || (!full[rd_bank_r] && !draining_r && has_data_s);

    // Next-state selection for the control FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            INIT:       state_s = WAIT_EMPTY;
            WAIT_EMPTY: begin
                if (|full)        state_s = ERROR;
                else if (&empty)  state_s = STREAM;
                else              state_s = WAIT_EMPTY;
            end
            STREAM: begin
                if (fault_s) state_s = ERROR;
                else         state_s = STREAM;
            end
            ERROR: begin
`ifdef PPB_AUTO_RECOVER_EN
                if (recover_cnt_r == 2'd3) state_s = INIT;
                else                       state_s = ERROR;
`else
                state_s = ERROR;
`endif
            end
            default: state_s = ERROR;
        endcase
    end

    // Bank resets and the one-hot write/read enables
    always_comb begin
        bank_rst = {NUM_BANKS{1'b0}};
        wr_en    = {NUM_BANKS{1'b0}};
        rd_en    = {NUM_BANKS{1'b0}};
        if (state_r == INIT || state_r == ERROR) begin
            bank_rst = {NUM_BANKS{1'b1}};
        end else if (state_r == STREAM) begin
            wr_en[wr_bank_r] = src_valid && has_room_s && !full[wr_bank_r];
            rd_en[rd_bank_r] = has_data_s && dst_ready && !empty[rd_bank_r];
        end else begin
            bank_rst = {NUM_BANKS{1'b0}};
        end
    end

    // State, pointers, occupancy, drain flag, sticky error and transfer count
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= INIT;
            wr_bank_r  <= {IDX_W{1'b0}};
            rd_bank_r  <= {IDX_W{1'b0}};
            occ_r      <= {(IDX_W+1){1'b0}};
            draining_r <= 1'b0;
            err_r      <= 1'b0;
            xfer_cnt_r <= {CNT_W{1'b0}};
`ifdef PPB_AUTO_RECOVER_EN
            recover_cnt_r <= 2'd0;
`endif
        end else begin
            state_r <= state_s;
            if (state_s == ERROR) err_r <= 1'b1;
            if (state_r == STREAM && !fault_s) begin
                if (commit_s) wr_bank_r <= next_idx(wr_bank_r);
                if (drain_done_s) begin
                    rd_bank_r  <= next_idx(rd_bank_r);
                    draining_r <= 1'b0;
                    xfer_cnt_r <= xfer_cnt_r + CNT_ONE;
                end else if (|rd_en) begin
                    draining_r <= 1'b1;
                end
                case ({commit_s, drain_done_s})
                    2'b10:   occ_r <= occ_r + OCC_ONE;
                    2'b01:   occ_r <= occ_r - OCC_ONE;
                    default: occ_r <= occ_r;
                endcase
            end
`ifdef PPB_AUTO_RECOVER_EN
            if (state_r == ERROR) begin
                recover_cnt_r <= recover_cnt_r + 2'd1;
                if (recover_cnt_r == 2'd3) begin
                    wr_bank_r  <= {IDX_W{1'b0}};
                    rd_bank_r  <= {IDX_W{1'b0}};
                    occ_r      <= {(IDX_W+1){1'b0}};
                    draining_r <= 1'b0;
                end
            end
`endif
        end
    end

    assign wr_bank   = wr_bank_r;
    assign rd_bank   = rd_bank_r;
    assign occ       = occ_r;
    assign src_stall = (occ_r == NB);
    assign err       = err_r;
    assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: a 2-bank and a 3-bank instance with hand-computed expectations.
module tb_pingpong_bank_ctrl;

    logic clk = 1'b0;
    logic reset, src_valid, dst_ready;
    logic [1:0] full2, empty2, bank_rst2, wr_en2, rd_en2, occ2;
    logic       wr_bank2, rd_bank2, src_stall2, err2;
    logic [15:0] xfer2;
    logic [2:0] full3, empty3, bank_rst3, wr_en3, rd_en3, occ3;
    logic [1:0] wr_bank3, rd_bank3;
    logic       src_stall3, err3;
    logic [15:0] xfer3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pingpong_bank_ctrl #(.NUM_BANKS(2)) u2 (
        .clk(clk), .reset(reset), .full(full2), .empty(empty2),
        .src_valid(src_valid), .dst_ready(dst_ready),
        .bank_rst(bank_rst2), .wr_en(wr_en2), .rd_en(rd_en2),
        .wr_bank(wr_bank2), .rd_bank(rd_bank2), .occ(occ2),
        .src_stall(src_stall2), .err(err2), .xfer_cnt(xfer2)
    );

    pingpong_bank_ctrl #(.NUM_BANKS(3)) u3 (
        .clk(clk), .reset(reset), .full(full3), .empty(empty3),
        .src_valid(src_valid), .dst_ready(dst_ready),
        .bank_rst(bank_rst3), .wr_en(wr_en3), .rd_en(rd_en3),
        .wr_bank(wr_bank3), .rd_bank(rd_bank3), .occ(occ3),
        .src_stall(src_stall3), .err(err3), .xfer_cnt(xfer3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; src_valid = 1'b0; dst_ready = 1'b0;
        full2 = 2'b00; empty2 = 2'b11; full3 = 3'b000; empty3 = 3'b111;
        tick(); tick();
        checks++; if (bank_rst2 !== 2'b11) begin errors++; $display("FAIL rst_bank_rst: got %b expected 11", bank_rst2); end
        checks++; if ({wr_en2, rd_en2} !== 4'b0000) begin errors++; $display("FAIL rst_enables: got %b expected 0000", {wr_en2, rd_en2}); end
        checks++; if ({wr_bank2, rd_bank2, occ2, err2} !== 5'b00000) begin errors++; $display("FAIL rst_regs: got %b expected 00000", {wr_bank2, rd_bank2, occ2, err2}); end
        checks++; if (xfer2 !== 16'd0) begin errors++; $display("FAIL rst_xfer: got %0d expected 0", xfer2); end
        reset = 1'b0; src_valid = 1'b1;
        tick();
        checks++; if ({bank_rst2, wr_en2} !== 4'b0000) begin errors++; $display("FAIL wait_empty_outs: got %b expected 0000", {bank_rst2, wr_en2}); end
        tick();
        checks++; if (wr_en2 !== 2'b01) begin errors++; $display("FAIL first_wr_en: got %b expected 01", wr_en2); end
        checks++; if (rd_en2 !== 2'b00) begin errors++; $display("FAIL first_rd_en: got %b expected 00", rd_en2); end
    endtask

    task automatic test_commit;
        full2 = 2'b01; empty2 = 2'b10; dst_ready = 1'b1;
        #1;
        checks++; if (wr_en2 !== 2'b00) begin errors++; $display("FAIL full_blocks_wr: got %b expected 00", wr_en2); end
        tick();
        checks++; if ({wr_bank2, occ2} !== 3'b101) begin errors++; $display("FAIL commit_ptr_occ: got %b expected 101", {wr_bank2, occ2}); end
        checks++; if (wr_en2 !== 2'b10) begin errors++; $display("FAIL overlap_wr_en: got %b expected 10", wr_en2); end
        checks++; if (rd_en2 !== 2'b01) begin errors++; $display("FAIL overlap_rd_en: got %b expected 01", rd_en2); end
    endtask

    task automatic test_drain_commit;
        tick();
        full2 = 2'b00;
        tick();
        full2 = 2'b10; empty2 = 2'b01;
        tick();
        checks++; if (occ2 !== 2'd1) begin errors++; $display("FAIL both_occ: got %0d expected 1", occ2); end
        checks++; if ({rd_bank2, wr_bank2} !== 2'b10) begin errors++; $display("FAIL both_ptrs: got %b expected 10", {rd_bank2, wr_bank2}); end
        checks++; if (xfer2 !== 16'd1) begin errors++; $display("FAIL both_xfer: got %0d expected 1", xfer2); end
        checks++; if ({wr_en2, rd_en2, err2} !== 5'b01100) begin errors++; $display("FAIL both_enables: got %b expected 01100", {wr_en2, rd_en2, err2}); end
    endtask

    task automatic test_error;
        full2 = 2'b10; empty2 = 2'b11;
        tick();
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err2); end
        checks++; if ({bank_rst2, wr_en2, rd_en2} !== 6'b110000) begin errors++; $display("FAIL err_outs: got %b expected 110000", {bank_rst2, wr_en2, rd_en2}); end
        full2 = 2'b00; empty2 = 2'b11;
`ifdef PPB_AUTO_RECOVER_EN
        tick(); tick(); tick();
        checks++; if ({bank_rst2, occ2, rd_bank2} !== 5'b11011) begin errors++; $display("FAIL recover_hold: got %b expected 11011", {bank_rst2, occ2, rd_bank2}); end
        tick();
        checks++; if ({bank_rst2, occ2, rd_bank2, wr_bank2, err2} !== 7'b1100001) begin errors++; $display("FAIL recover_init: got %b expected 1100001", {bank_rst2, occ2, rd_bank2, wr_bank2, err2}); end
        checks++; if (xfer2 !== 16'd1) begin errors++; $display("FAIL recover_xfer: got %0d expected 1", xfer2); end
        tick();
        checks++; if ({bank_rst2, err2} !== 3'b001) begin errors++; $display("FAIL recover_wait: got %b expected 001", {bank_rst2, err2}); end
`else
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({err2, bank_rst2, wr_en2, rd_en2} !== 7'b1110000) begin errors++; $display("FAIL err_terminal: got %b expected 1110000", {err2, bank_rst2, wr_en2, rd_en2}); end
        checks++; if ({occ2, rd_bank2, wr_bank2} !== 4'b0110) begin errors++; $display("FAIL err_frozen: got %b expected 0110", {occ2, rd_bank2, wr_bank2}); end
`endif
    endtask

    task automatic test_fill3;
        dst_ready = 1'b0;
        full3 = 3'b001; empty3 = 3'b110;
        tick();
        checks++; if ({wr_bank3, occ3, wr_en3} !== 8'b01_001_010) begin errors++; $display("FAIL fill3_step1: got %b expected 01001010", {wr_bank3, occ3, wr_en3}); end
        full3 = 3'b011; empty3 = 3'b100;
        tick();
        full3 = 3'b111; empty3 = 3'b000;
        tick();
        checks++; if ({occ3, src_stall3} !== 4'b0111) begin errors++; $display("FAIL fill3_stall: got %b expected 0111", {occ3, src_stall3}); end
        checks++; if ({wr_bank3, rd_bank3, wr_en3, rd_en3} !== 10'b0) begin errors++; $display("FAIL fill3_wrap_enables: got %b expected 0", {wr_bank3, rd_bank3, wr_en3, rd_en3}); end
        dst_ready = 1'b1;
        #1;
        checks++; if (rd_en3 !== 3'b001) begin errors++; $display("FAIL fill3_rd_en: got %b expected 001", rd_en3); end
        tick();
        full3 = 3'b110;
        tick();
        empty3 = 3'b001;
        tick();
        checks++; if ({occ3, src_stall3, rd_bank3, wr_bank3} !== 8'b010_0_01_00) begin errors++; $display("FAIL fill3_drain: got %b expected 01000100", {occ3, src_stall3, rd_bank3, wr_bank3}); end
        checks++; if ({wr_en3, rd_en3} !== 6'b001010) begin errors++; $display("FAIL fill3_reopen: got %b expected 001010", {wr_en3, rd_en3}); end
        checks++; if (xfer3 !== 16'd1) begin errors++; $display("FAIL fill3_xfer: got %0d expected 1", xfer3); end
    endtask

    task automatic test_reset_mid_drain;
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({occ3, wr_bank3, rd_bank3, err3} !== 8'b0) begin errors++; $display("FAIL midrst_regs: got %b expected 0", {occ3, wr_bank3, rd_bank3, err3}); end
        checks++; if (xfer3 !== 16'd0) begin errors++; $display("FAIL midrst_xfer: got %0d expected 0", xfer3); end
        checks++; if ({bank_rst3, wr_en3, rd_en3} !== 9'b111_000_000) begin errors++; $display("FAIL midrst_outs: got %b expected 111000000", {bank_rst3, wr_en3, rd_en3}); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL midrst_err2: got %b expected 0", err2); end
        reset = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_commit();
        test_drain_commit();
        test_error();
        test_fill3();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
